stream_ctrl: RTL and testbench

Playback controller between the sample FIFO and the modulator. It tracks FIFO occupancy from the write/read strobes and holds the modulator disabled until a prefill level is reached. It gates modulator read requests into FIFO reads, detects underruns and re-enters prefill on one. It also sends a periodic and event-driven status byte to the host over the FT245 wrapper's TX simple interface.

---
 rtl/stream_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_stream_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_ctrl.sv
// -----------------------------------------------------------------------------
// stream_ctrl
//
// Playback controller between the sample FIFO and the modulator.
//   * Tracks FIFO occupancy from the write strobe and the gated read strobe.
//   * Holds the modulator disabled (PREFILL) until the occupancy reaches
//     START_LEVEL or the FIFO reports full, then runs (RUN).
//   * Gates modulator read requests into FIFO reads. On an underrun (a read
//     request against an empty FIFO while running) it pulses underrun_o,
//     counts the event and drops back to PREFILL.
//   * Emits a status byte over a valid/ready TX interface. A byte is sent
//     every STATUS_PERIOD cycles and on every underrun. A trigger that
//     arrives while a byte is still pending is dropped.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   arm_i          in   playback allowed; low forces IDLE
//   wr_en_i        in   FIFO write strobe
//   fifo_empty_i   in   FIFO empty flag
//   fifo_full_i    in   FIFO full flag
//   rd_req_i       in   modulator read request
//   rd_en_o        out  FIFO read enable (combinational)
//   mod_enable_o   out  modulator enable (registered, high in RUN)
//   level_o        out  tracked occupancy, 0..2^DEPTH_WIDTH
//   state_o        out  0=IDLE, 1=PREFILL, 2=RUN
//   underrun_o     out  one-cycle pulse per underrun
//   underrun_cnt_o out  saturating underrun count
//   tx_data_o      out  status byte {sticky_underrun, state[1:0], level top 5 bits}
//   tx_valid_o     out  status byte valid
//   tx_ready_i     in   TX sink ready
// -----------------------------------------------------------------------------
module stream_ctrl #(
  parameter int unsigned DEPTH_WIDTH   = 8,
  parameter int unsigned START_LEVEL   = 128,
  parameter int unsigned STATUS_PERIOD = 1200000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm_i,
  input  logic                   wr_en_i,
  input  logic                   fifo_empty_i,
  input  logic                   fifo_full_i,
  input  logic                   rd_req_i,
  output logic                   rd_en_o,
  output logic                   mod_enable_o,
  output logic [DEPTH_WIDTH:0]   level_o,
  output logic [1:0]             state_o,
  output logic                   underrun_o,
  output logic [7:0]             underrun_cnt_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i
);

  localparam int unsigned LEVEL_W = DEPTH_WIDTH + 1;

  // Full-FIFO occupancy is 2^DEPTH_WIDTH, i.e. only the MSB set.
  localparam logic [DEPTH_WIDTH:0] LEVEL_MAX = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] START_LVL = LEVEL_W'(START_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic                 mod_enable_reg;
  logic [DEPTH_WIDTH:0] level_reg;
  logic [DEPTH_WIDTH:0] level_next;
  logic                 underrun_reg;
  logic [7:0]           underrun_cnt_reg;
  logic                 sticky_reg;
  logic                 tx_valid_reg;
  logic [7:0]           tx_data_reg;

  logic                 rd_en;
  logic                 underrun_det;
  logic                 timer_tc;
  logic                 report_trig;
  logic                 capture;
  logic [4:0]           level_field;
  logic [7:0]           status_byte;

  // ---------------------------------------------------------------------------
  // Read gating and underrun detection
  // ---------------------------------------------------------------------------
  assign rd_en        = (state_reg == ST_RUN) & rd_req_i & ~fifo_empty_i;
  assign underrun_det = (state_reg == ST_RUN) & rd_req_i &  fifo_empty_i;

  // ---------------------------------------------------------------------------
  // Occupancy tracking. A simultaneous write and read cancel out. The
  // saturation guards only matter if the strobes ever disagree with the
  // FIFO's own view of occupancy.
  // ---------------------------------------------------------------------------
  always_comb begin
    level_next = level_reg;
    if (wr_en_i && !rd_en) begin
      if (level_reg != LEVEL_MAX) begin
        level_next = level_reg + 1'b1;
      end
    end else if (rd_en && !wr_en_i) begin
      if (level_reg != '0) begin
        level_next = level_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= '0;
    end else begin
      level_reg <= level_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Playback FSM. Disarm wins over every other transition. The start check
  // uses the registered level, so RUN begins one edge after the level
  // reaches START_LEVEL.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (!arm_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_PREFILL;
        end
        ST_PREFILL: begin
          if ((level_reg >= START_LVL) || fifo_full_i) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (underrun_det) begin
            state_next = ST_PREFILL;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      mod_enable_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mod_enable_reg <= (state_next == ST_RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Underrun pulse and saturating counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
    end else begin
      underrun_reg <= underrun_det;
      if (underrun_det && (underrun_cnt_reg != 8'hFF)) begin
        underrun_cnt_reg <= underrun_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Periodic status timer: counts 0..STATUS_PERIOD-1 and fires on the
  // terminal count. A period of zero removes the timer entirely.
  // ---------------------------------------------------------------------------
  generate
    if (STATUS_PERIOD == 0) begin : g_no_timer
      assign timer_tc = 1'b0;
    end else begin : g_timer
      localparam int unsigned TIMER_W = (STATUS_PERIOD > 1) ? $clog2(STATUS_PERIOD) : 1;
      localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STATUS_PERIOD - 1);

      logic [TIMER_W-1:0] timer_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          timer_reg <= '0;
        end else if (timer_reg == TIMER_LAST) begin
          timer_reg <= '0;
        end else begin
          timer_reg <= timer_reg + 1'b1;
        end
      end

      assign timer_tc = (timer_reg == TIMER_LAST);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Status byte. The fields are the values that become visible on the
  // outputs at the capture edge, so a byte raised by an underrun already
  // reports PREFILL and carries the underrun flag.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_level_field
      assign level_field[gi] = level_next[DEPTH_WIDTH-4+gi];
    end
  endgenerate

  assign status_byte = {sticky_reg | underrun_det, state_next, level_field};
  assign report_trig = underrun_det | timer_tc;

  // No queue: a trigger that finds a byte still pending is simply lost.
  assign capture = report_trig & ~tx_valid_reg;

  // Sticky underrun flag: consumed by a captured byte, but an underrun in
  // the capture cycle keeps it set so the following byte reports it too.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_reg <= 1'b0;
    end else begin
      sticky_reg <= underrun_det | (sticky_reg & ~capture);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else if (capture) begin
      tx_valid_reg <= 1'b1;
      tx_data_reg  <= status_byte;
    end else if (tx_valid_reg && tx_ready_i) begin
      tx_valid_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_en_o        = rd_en;
  assign mod_enable_o   = mod_enable_reg;
  assign level_o        = level_reg;
  assign state_o        = state_reg;
  assign underrun_o     = underrun_reg;
  assign underrun_cnt_o = underrun_cnt_reg;
  assign tx_data_o      = tx_data_reg;
  assign tx_valid_o     = tx_valid_reg;

endmodule

// File: tb/tb_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stream_ctrl
//
// Directed testbench for stream_ctrl with DEPTH_WIDTH=4, START_LEVEL=4 and
// STATUS_PERIOD=16. Each scenario task drives its own stimulus and checks
// hand-computed expected values inline. tm_phase follows the free-running
// status timer (reset to 0, wraps after 15) so that scenarios can line up
// with periodic reports.
// -----------------------------------------------------------------------------
module tb_stream_ctrl;

  localparam int DW     = 4;
  localparam int START  = 4;
  localparam int PERIOD = 16;

  logic         clk;
  logic         rst;
  logic         arm_i;
  logic         wr_en_i;
  logic         fifo_empty_i;
  logic         fifo_full_i;
  logic         rd_req_i;
  logic         rd_en_o;
  logic         mod_enable_o;
  logic [DW:0]  level_o;
  logic [1:0]   state_o;
  logic         underrun_o;
  logic [7:0]   underrun_cnt_o;
  logic [7:0]   tx_data_o;
  logic         tx_valid_o;
  logic         tx_ready_i;

  int n_checks = 0;
  int n_fail   = 0;
  int tm_phase = 0;

  stream_ctrl #(
    .DEPTH_WIDTH   (DW),
    .START_LEVEL   (START),
    .STATUS_PERIOD (PERIOD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .arm_i          (arm_i),
    .wr_en_i        (wr_en_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_full_i    (fifo_full_i),
    .rd_req_i       (rd_req_i),
    .rd_en_o        (rd_en_o),
    .mod_enable_o   (mod_enable_o),
    .level_o        (level_o),
    .state_o        (state_o),
    .underrun_o     (underrun_o),
    .underrun_cnt_o (underrun_cnt_o),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tm_phase <= 0;
    else     tm_phase <= (tm_phase == PERIOD - 1) ? 0 : tm_phase + 1;
  end

  // One line per TX transaction.
  always @(posedge clk) begin
    if (!rst && tx_valid_o && tx_ready_i)
      $display("[%0t] tx handshake data=0x%02h", $time, tx_data_o);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; arm_i = 1'b0; wr_en_i = 1'b0; fifo_empty_i = 1'b1;
    fifo_full_i = 1'b0; rd_req_i = 1'b0; tx_ready_i = 1'b1;
    step(); step();
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    n_checks++; if (mod_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_mod_en: got %0b expected 0", mod_enable_o); end
    n_checks++; if (level_o !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level_o); end
    n_checks++; if (underrun_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_ucnt: got %0d expected 0", underrun_cnt_o); end
    n_checks++; if (tx_valid_o !== 1'b0 || tx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_tx: got valid=%0b data=0x%02h expected 0/0x00", tx_valid_o, tx_data_o); end
    rst = 1'b0;
  endtask

  task automatic test_prefill();
    arm_i = 1'b1; rd_req_i = 1'b1; fifo_empty_i = 1'b1;
    step();
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL prefill_enter: got %0d expected 1", state_o); end
    for (int i = 1; i <= 4; i++) begin
      wr_en_i = 1'b1; fifo_empty_i = 1'b0;
      step();
      n_checks++; if (level_o !== 5'(i)) begin n_fail++; $display("FAIL prefill_level: got %0d expected %0d", level_o, i); end
      n_checks++; if (state_o !== 2'd1 || mod_enable_o !== 1'b0) begin n_fail++; $display("FAIL prefill_hold: got state=%0d mod=%0b expected 1/0", state_o, mod_enable_o); end
      #1;
      n_checks++; if (rd_en_o !== 1'b0) begin n_fail++; $display("FAIL prefill_rd_en: got %0b expected 0", rd_en_o); end
    end
    wr_en_i = 1'b0; rd_req_i = 1'b0;
    step();
    n_checks++; if (state_o !== 2'd2 || mod_enable_o !== 1'b1) begin n_fail++; $display("FAIL prefill_start: got state=%0d mod=%0b expected 2/1", state_o, mod_enable_o); end
    n_checks++; if (level_o !== 5'd4) begin n_fail++; $display("FAIL prefill_level_hold: got %0d expected 4", level_o); end
  endtask

  task automatic test_simultaneous();
    wr_en_i = 1'b1; rd_req_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_checks++; if (level_o !== 5'd10) begin n_fail++; $display("FAIL simul_fill: got %0d expected 10", level_o); end
    rd_req_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (rd_en_o !== 1'b1) begin n_fail++; $display("FAIL simul_rd_en: got %0b expected 1", rd_en_o); end
      step();
      n_checks++; if (level_o !== 5'd10) begin n_fail++; $display("FAIL simul_level: got %0d expected 10", level_o); end
    end
    wr_en_i = 1'b0; rd_req_i = 1'b0;
  endtask

  task automatic test_underrun();
    rd_req_i = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      #1;
      n_checks++; if (rd_en_o !== 1'b1) begin n_fail++; $display("FAIL drain_rd_en: got %0b expected 1", rd_en_o); end
      step();
      n_checks++; if (level_o !== 5'(i)) begin n_fail++; $display("FAIL drain_level: got %0d expected %0d", level_o, i); end
    end
    rd_req_i = 1'b0; fifo_empty_i = 1'b1;
    // keep the underrun cycle clear of a pending periodic byte
    if (tm_phase == 0) step();
    rd_req_i = 1'b1;
    #1;
    n_checks++; if (rd_en_o !== 1'b0) begin n_fail++; $display("FAIL underrun_rd_en: got %0b expected 0", rd_en_o); end
    step();
    n_checks++; if (underrun_o !== 1'b1) begin n_fail++; $display("FAIL underrun_pulse: got %0b expected 1", underrun_o); end
    n_checks++; if (underrun_cnt_o !== 8'd1) begin n_fail++; $display("FAIL underrun_cnt: got %0d expected 1", underrun_cnt_o); end
    n_checks++; if (state_o !== 2'd1 || mod_enable_o !== 1'b0) begin n_fail++; $display("FAIL underrun_state: got state=%0d mod=%0b expected 1/0", state_o, mod_enable_o); end
    n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hA0) begin n_fail++; $display("FAIL underrun_byte: got valid=%0b data=0x%02h expected 1/0xa0", tx_valid_o, tx_data_o); end
    step();
    n_checks++; if (underrun_o !== 1'b0) begin n_fail++; $display("FAIL underrun_single: got %0b expected 0", underrun_o); end
    n_checks++; if (underrun_cnt_o !== 8'd1 || state_o !== 2'd1) begin n_fail++; $display("FAIL underrun_after: got cnt=%0d state=%0d expected 1/1", underrun_cnt_o, state_o); end
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL underrun_tx_done: got %0b expected 0", tx_valid_o); end
    rd_req_i = 1'b0;
  endtask

  task automatic test_backpressure();
    bit found;
    tx_ready_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (tm_phase == 0) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL bp_wait: got no periodic edge expected one within 20 cycles"); end
    // sticky survived the underrun byte because the underrun hit the capture cycle
    n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hA0) begin n_fail++; $display("FAIL bp_capture: got valid=%0b data=0x%02h expected 1/0xa0", tx_valid_o, tx_data_o); end
    for (int j = 0; j < 20; j++) begin
      wr_en_i = (j < 3);
      step();
      n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hA0) begin n_fail++; $display("FAIL bp_stable: got valid=%0b data=0x%02h expected 1/0xa0", tx_valid_o, tx_data_o); end
    end
    wr_en_i = 1'b0; tx_ready_i = 1'b1;
    step();
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: got %0b expected 0", tx_valid_o); end
    for (int j = 0; j < 5; j++) begin
      step();
      n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_dropped: got %0b expected 0", tx_valid_o); end
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (tm_phase == 0) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL bp_wait2: got no periodic edge expected one within 20 cycles"); end
    n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h23) begin n_fail++; $display("FAIL bp_next_byte: got valid=%0b data=0x%02h expected 1/0x23", tx_valid_o, tx_data_o); end
    step();
  endtask

  task automatic test_disarm_reset();
    bit found;
    wr_en_i = 1'b1;
    step();
    wr_en_i = 1'b0;
    step();
    n_checks++; if (state_o !== 2'd2 || mod_enable_o !== 1'b1) begin n_fail++; $display("FAIL disarm_pre: got state=%0d mod=%0b expected 2/1", state_o, mod_enable_o); end
    arm_i = 1'b0;
    step();
    n_checks++; if (state_o !== 2'd0 || mod_enable_o !== 1'b0) begin n_fail++; $display("FAIL disarm: got state=%0d mod=%0b expected 0/0", state_o, mod_enable_o); end
    tx_ready_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (tm_phase == 0) found = 1'b1;
    end
    n_checks++; if (!found || tx_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %0b expected 1", tx_valid_o); end
    rst = 1'b1;
    step();
    n_checks++; if (tx_valid_o !== 1'b0 || tx_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_tx: got valid=%0b data=0x%02h expected 0/0x00", tx_valid_o, tx_data_o); end
    n_checks++; if (level_o !== 5'd0 || underrun_cnt_o !== 8'd0) begin n_fail++; $display("FAIL rst_counts: got level=%0d cnt=%0d expected 0/0", level_o, underrun_cnt_o); end
    n_checks++; if (state_o !== 2'd0 || mod_enable_o !== 1'b0 || underrun_o !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl: got state=%0d mod=%0b ur=%0b expected 0/0/0", state_o, mod_enable_o, underrun_o); end
    rst = 1'b0; tx_ready_i = 1'b1;
  endtask

  task automatic test_full_start();
    arm_i = 1'b1;
    step();
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL full_prefill: got %0d expected 1", state_o); end
    fifo_full_i = 1'b1;
    step();
    n_checks++; if (state_o !== 2'd2 || level_o !== 5'd0) begin n_fail++; $display("FAIL full_start: got state=%0d level=%0d expected 2/0", state_o, level_o); end
    fifo_full_i = 1'b0; arm_i = 1'b0;
    step();
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL full_disarm: got %0d expected 0", state_o); end
  endtask

  task automatic test_periodic();
    int exp_level;
    int bytes;
    logic exp_valid;
    logic [7:0] exp_byte;
    rst = 1'b1;
    step();
    rst = 1'b0; arm_i = 1'b0; tx_ready_i = 1'b1;
    exp_level = 0;
    bytes = 0;
    for (int k = 1; k <= 48; k++) begin
      wr_en_i = (k <= 5) || (k > 16 && k <= 23) || (k > 32 && k <= 35);
      step();
      if (wr_en_i) exp_level++;
      n_checks++; if (level_o !== 5'(exp_level)) begin n_fail++; $display("FAIL per_level k=%0d: got %0d expected %0d", k, level_o, exp_level); end
      exp_valid = ((k % PERIOD) == 0);
      n_checks++; if (tx_valid_o !== exp_valid) begin n_fail++; $display("FAIL per_valid k=%0d: got %0b expected %0b", k, tx_valid_o, exp_valid); end
      if (exp_valid) begin
        bytes++;
        exp_byte = {3'b000, 5'(exp_level)};
        n_checks++; if (tx_data_o !== exp_byte) begin n_fail++; $display("FAIL per_data k=%0d: got 0x%02h expected 0x%02h", k, tx_data_o, exp_byte); end
      end
    end
    wr_en_i = 1'b0;
    n_checks++; if (bytes != 3) begin n_fail++; $display("FAIL per_count: got %0d expected 3", bytes); end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_simultaneous();
    test_underrun();
    test_backpressure();
    test_disarm_reset();
    test_full_start();
    test_periodic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
